instr_decoder: RTL and testbench

INSTR_DECODER -- requirements
Module: instr_decoder

---
 rtl/instr_decoder_pkg.sv | 36 +++
 rtl/instr_decoder_opcode_rom.sv | 29 ++
 rtl/instr_decoder.sv | 160 ++++++++++++++++
 tb/tb_instr_decoder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/instr_decoder_pkg.sv
// Shared opcode values, FSM state encoding and one-hot line indices for instr_decoder.
package instr_decoder_pkg;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_STA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_INC = 4'h5;
    localparam logic [3:0] OP_CLR = 4'h6;
    localparam logic [3:0] OP_JMP = 4'h7;
    localparam logic [3:0] OP_JPZ = 4'h8;
    localparam logic [3:0] OP_JPN = 4'h9;
    localparam logic [3:0] OP_HLT = 4'hA;

    localparam int NUM_LINES = 11;
    localparam int IDX_LDA   = 0;
    localparam int IDX_STA   = 1;
    localparam int IDX_ADD   = 2;
    localparam int IDX_SUB   = 3;
    localparam int IDX_XOR   = 4;
    localparam int IDX_INC   = 5;
    localparam int IDX_CLR   = 6;
    localparam int IDX_JMP   = 7;
    localparam int IDX_JPZ   = 8;
    localparam int IDX_JPN   = 9;
    localparam int IDX_HLT   = 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_VALID  = 2'd2,
        ST_HALT   = 2'd3
    } state_t;

endpackage

// File: rtl/instr_decoder_opcode_rom.sv
// Combinational opcode lookup: 4-bit opcode to one-hot instruction lines plus illegal flag.
module opcode_rom
    import instr_decoder_pkg::*;
(
    input  logic [3:0]           i_opcode,
    output logic [NUM_LINES-1:0] o_onehot,
    output logic                 o_illegal
);

    always_comb begin
        o_onehot  = '0;
        o_illegal = 1'b0;
        case (i_opcode)
            OP_LDA:  o_onehot[IDX_LDA] = 1'b1;
            OP_STA:  o_onehot[IDX_STA] = 1'b1;
            OP_ADD:  o_onehot[IDX_ADD] = 1'b1;
            OP_SUB:  o_onehot[IDX_SUB] = 1'b1;
            OP_XOR:  o_onehot[IDX_XOR] = 1'b1;
            OP_INC:  o_onehot[IDX_INC] = 1'b1;
            OP_CLR:  o_onehot[IDX_CLR] = 1'b1;
            OP_JMP:  o_onehot[IDX_JMP] = 1'b1;
            OP_JPZ:  o_onehot[IDX_JPZ] = 1'b1;
            OP_JPN:  o_onehot[IDX_JPN] = 1'b1;
            OP_HLT:  o_onehot[IDX_HLT] = 1'b1;
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_decoder.sv
// Registered instruction decoder with Z/N flags and sticky halt.
// Optional macro ILLEGAL_TRAP_EN: illegal opcodes set illegal/halted and trap into HALT.
module instr_decoder
    import instr_decoder_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              startStop,
    input  logic [DATA_W-1:0] instr,
    input  logic              ir_load,
    input  logic [DATA_W-1:0] acc,
    input  logic              flag_load,
    output logic              LDA,
    output logic              STA,
    output logic              ADD,
    output logic              SUB,
    output logic              XOR,
    output logic              INC,
    output logic              CLR,
    output logic              JMP,
    output logic              JPZ,
    output logic              JPN,
    output logic              HLT,
    output logic [DATA_W-5:0] addr,
    output logic              dec_valid,
    output logic              branch_taken,
    output logic              halted,
    output logic              illegal,
    output logic [1:0]        o_state
);

    state_t                r_state, w_state_n;
    logic [DATA_W-1:0]     r_ir, w_ir_n;
    logic                  r_z, w_z_n;
    logic                  r_n, w_n_n;
    logic [NUM_LINES-1:0]  r_lines, w_lines_n;
    logic [DATA_W-5:0]     r_addr, w_addr_n;
    logic                  r_dec_valid, w_dec_valid_n;
    logic                  r_branch, w_branch_n;
    logic                  r_halted, w_halted_n;
    logic [NUM_LINES-1:0]  w_onehot;
    logic                  w_illegal;
    logic                  w_jump;
`ifdef ILLEGAL_TRAP_EN
    logic                  r_illegal, w_illegal_n;
`endif

    opcode_rom u_rom (
        .i_opcode  (r_ir[DATA_W-1:DATA_W-4]),
        .o_onehot  (w_onehot),
        .o_illegal (w_illegal)
    );

    // Branch decision uses the flags held during the DECODE cycle, not this edge's flag_load.
    assign w_jump = w_onehot[IDX_JMP] | (w_onehot[IDX_JPZ] & r_z) | (w_onehot[IDX_JPN] & r_n);
    assign w_z_n  = flag_load ? (acc == '0) : r_z;
    assign w_n_n  = flag_load ? acc[DATA_W-1] : r_n;

    always_comb begin
        w_state_n     = r_state;
        w_ir_n        = r_ir;
        w_lines_n     = r_lines;
        w_addr_n      = r_addr;
        w_dec_valid_n = r_dec_valid;
        w_branch_n    = r_branch;
        w_halted_n    = r_halted;
`ifdef ILLEGAL_TRAP_EN
        w_illegal_n   = r_illegal;
`endif
        case (r_state)
            ST_IDLE, ST_VALID: begin
                if (ir_load) begin
                    w_ir_n        = instr;
                    w_lines_n     = '0;
                    w_dec_valid_n = 1'b0;
                    w_branch_n    = 1'b0;
                    w_state_n     = ST_DECODE;
                end
            end
            ST_DECODE: begin
                w_lines_n     = w_illegal ? '0 : w_onehot;
                w_dec_valid_n = 1'b1;
                w_addr_n      = r_ir[DATA_W-5:0];
                w_branch_n    = w_jump;
                w_state_n     = ST_VALID;
                if (w_onehot[IDX_HLT]) begin
                    w_halted_n = 1'b1;
                    w_state_n  = ST_HALT;
                end
`ifdef ILLEGAL_TRAP_EN
                if (w_illegal) begin
                    w_illegal_n = 1'b1;
                    w_halted_n  = 1'b1;
                    w_state_n   = ST_HALT;
                end
`endif
            end
            ST_HALT: begin
                w_halted_n = 1'b1;
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!startStop) r_state <= ST_IDLE;
        else            r_state <= w_state_n;
    end

    always_ff @(posedge clock) begin
        if (!startStop) begin
            r_ir        <= '0;
            r_z         <= 1'b0;
            r_n         <= 1'b0;
            r_lines     <= '0;
            r_addr      <= '0;
            r_dec_valid <= 1'b0;
            r_branch    <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            r_ir        <= w_ir_n;
            r_z         <= w_z_n;
            r_n         <= w_n_n;
            r_lines     <= w_lines_n;
            r_addr      <= w_addr_n;
            r_dec_valid <= w_dec_valid_n;
            r_branch    <= w_branch_n;
            r_halted    <= w_halted_n;
        end
    end

`ifdef ILLEGAL_TRAP_EN
    always_ff @(posedge clock) begin
        if (!startStop) r_illegal <= 1'b0;
        else            r_illegal <= w_illegal_n;
    end
    assign illegal = r_illegal;
`else
    assign illegal = 1'b0;
`endif

    assign LDA          = r_lines[IDX_LDA];
    assign STA          = r_lines[IDX_STA];
    assign ADD          = r_lines[IDX_ADD];
    assign SUB          = r_lines[IDX_SUB];
    assign XOR          = r_lines[IDX_XOR];
    assign INC          = r_lines[IDX_INC];
    assign CLR          = r_lines[IDX_CLR];
    assign JMP          = r_lines[IDX_JMP];
    assign JPZ          = r_lines[IDX_JPZ];
    assign JPN          = r_lines[IDX_JPN];
    assign HLT          = r_lines[IDX_HLT];
    assign addr         = r_addr;
    assign dec_valid    = r_dec_valid;
    assign branch_taken = r_branch;
    assign halted       = r_halted;
    assign o_state      = r_state;

endmodule

// File: tb/tb_instr_decoder.sv
// Scoreboard bench for instr_decoder: random instructions and flag loads against an opcode-table model.
module tb_instr_decoder;

  logic       clock = 1'b0;
  logic       startStop = 1'b0;
  logic [7:0] instr = '0;
  logic       ir_load = 1'b0;
  logic [7:0] acc = '0;
  logic       flag_load = 1'b0;
  logic       LDA, STA, ADD, SUB, XOR, INC, CLR, JMP, JPZ, JPN, HLT;
  logic [3:0] addr;
  logic       dec_valid, branch_taken, halted, illegal;
  logic [1:0] o_state;

`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  int vectors = 0;
  int miscompares = 0;

  // {lines[10:0] (bit i = opcode i), addr, branch_taken, halted, illegal}
  logic [17:0] exp_q[$];
  logic [17:0] dut_vec;
  logic [17:0] m_last = '0;
  logic        m_z = 1'b0;
  logic        m_n = 1'b0;
  bit          m_halted = 1'b0;
  logic        prev_dv = 1'b0;

  assign dut_vec = {HLT, JPN, JPZ, JMP, CLR, INC, XOR, SUB, ADD, STA, LDA,
                    addr, branch_taken, halted, illegal};

  instr_decoder #(.DATA_W(8)) dut (
    .clock(clock), .startStop(startStop), .instr(instr), .ir_load(ir_load),
    .acc(acc), .flag_load(flag_load),
    .LDA(LDA), .STA(STA), .ADD(ADD), .SUB(SUB), .XOR(XOR), .INC(INC), .CLR(CLR),
    .JMP(JMP), .JPZ(JPZ), .JPN(JPN), .HLT(HLT),
    .addr(addr), .dec_valid(dec_valid), .branch_taken(branch_taken),
    .halted(halted), .illegal(illegal), .o_state(o_state)
  );

  always #5 clock = ~clock;

  // Reference model: expected response for one instruction given the current flags.
  function automatic logic [17:0] model(input logic [7:0] ins, input logic z, input logic n);
    int op;
    logic [10:0] lines;
    logic br, hlt, ill;
    op    = int'(ins[7:4]);
    lines = (op <= 10) ? (11'd1 << op) : 11'd0;
    br    = (op == 7) || (op == 8 && z) || (op == 9 && n);
    ill   = TRAP && (op > 10);
    hlt   = (op == 10) || ill;
    return {lines, ins[3:0], br, hlt, ill};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic model_flags(input logic [7:0] a);
    m_z = (a == 8'h00);
    m_n = a[7];
  endtask

  task automatic do_reset();
    startStop = 1'b0;
    ir_load = 1'b1;
    flag_load = 1'b1;
    acc = 8'h80;
    step();
    step();
    startStop = 1'b1;
    ir_load = 1'b0;
    flag_load = 1'b0;
    m_z = 1'b0;
    m_n = 1'b0;
    m_halted = 1'b0;
    m_last = '0;
    @(negedge clock);
    vectors++;
    if ({dut_vec, dec_valid, o_state} !== 21'd0) begin
      miscompares++;
      $display("FAIL reset_state got=%h want=0", {dut_vec, dec_valid, o_state});
    end
  endtask

  task automatic do_flag(input logic [7:0] a);
    flag_load = 1'b1;
    acc = a;
    step();
    flag_load = 1'b0;
    model_flags(a);
  endtask

  // flag_same: flag_load on the ir_load edge; flag_after: flag_load on the decode edge;
  // dbl: keep ir_load high into DECODE with a different word, which must be ignored.
  task automatic issue(input logic [7:0] ins, input bit flag_same, input logic [7:0] a_same,
                       input bit flag_after, input logic [7:0] a_after, input bit dbl);
    logic [17:0] e;
    if (m_halted) begin
      instr = ins;
      ir_load = 1'b1;
      step();
      ir_load = 1'b0;
      step();
      step();
      @(negedge clock);
      vectors++;
      if ({dut_vec, dec_valid} !== {m_last, 1'b1}) begin
        miscompares++;
        $display("FAIL halt_hold got=%h want=%h", {dut_vec, dec_valid}, {m_last, 1'b1});
      end
    end else begin
      if (flag_same) model_flags(a_same);
      e = model(ins, m_z, m_n);
      exp_q.push_back(e);
      m_last = e;
      instr = ins;
      ir_load = 1'b1;
      flag_load = flag_same;
      acc = a_same;
      step();
      ir_load = dbl;
      instr = ~ins;
      flag_load = flag_after;
      acc = a_after;
      step();
      ir_load = 1'b0;
      flag_load = 1'b0;
      if (flag_after) model_flags(a_after);
      @(negedge clock);
      vectors++;
      if (dec_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL decode_latency dec_valid=%b want=1", dec_valid);
      end
      if (e[1]) m_halted = 1'b1;
    end
  endtask

  // Monitor: every rising dec_valid presents one decoded instruction.
  always @(negedge clock) begin
    logic [17:0] e;
    if (dec_valid && !prev_dv) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_decode got=%h want=none", dut_vec);
      end else begin
        e = exp_q.pop_front();
        if (dut_vec !== e) begin
          miscompares++;
          $display("FAIL decode got=%h want=%h", dut_vec, e);
        end
      end
    end
    prev_dv <= dec_valid;
  end

  initial begin
    do_reset();
    issue(8'h2A, 0, 8'h00, 0, 8'h00, 0);
    do_flag(8'h00);
    issue(8'h85, 0, 8'h00, 0, 8'h00, 0);
    do_flag(8'h01);
    issue(8'h85, 0, 8'h00, 0, 8'h00, 0);
    do_flag(8'h80);
    issue(8'h93, 0, 8'h00, 0, 8'h00, 0);
    issue(8'hF0, 0, 8'h00, 0, 8'h00, 0);
    issue(8'h50, 0, 8'h00, 0, 8'h00, 0);
    do_reset();
    issue(8'h7C, 0, 8'h00, 1, 8'h00, 1);
    issue(8'h85, 1, 8'h00, 1, 8'h01, 0);
    issue(8'h85, 0, 8'h00, 0, 8'h00, 0);
    issue(8'hA0, 0, 8'h00, 0, 8'h00, 0);
    issue(8'h10, 0, 8'h00, 0, 8'h00, 0);
    do_reset();
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) do_flag(8'($urandom_range(0, 255)));
      issue(8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)));
      if (m_halted && $urandom_range(0, 1) == 1) do_reset();
    end
    step();
    step();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL pending_decodes got=%0d want=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
